// File: rtl/sram_1rw1r_pipe.sv
// sram_1rw1r_pipe: parametrised single-clock 1RW+1R SRAM model.
// Port 0 reads or writes with a per-lane write mask; port 1 is read-only.
// Features: valid/ready request handshakes, per-port response valid,
// same-edge write->read forwarding and an optional post-reset clear sweep.
module sram_1rw1r_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int DEPTH          = 256,
  parameter int WMASK_WIDTH    = 4,
  parameter int READ_LATENCY   = 1,
  parameter int FORWARD        = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                   clk0,
  input  logic                   rst_n,
  output logic                   init_done,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic                   req0_we,
  input  logic [WMASK_WIDTH-1:0] req0_wmask,
  input  logic [ADDR_WIDTH-1:0]  req0_addr,
  input  logic [DATA_WIDTH-1:0]  req0_wdata,
  output logic                   rsp0_valid,
  output logic [DATA_WIDTH-1:0]  rsp0_rdata,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [ADDR_WIDTH-1:0]  req1_addr,
  output logic                   rsp1_valid,
  output logic [DATA_WIDTH-1:0]  rsp1_rdata
);

  localparam int LANE_W = DATA_WIDTH / WMASK_WIDTH;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0]    IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]    IDX_ZERO  = IDX_W'(0);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = DATA_WIDTH'(0);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  // Widen a lane mask into a per-bit mask.
  function automatic logic [DATA_WIDTH-1:0] expand_mask(input logic [WMASK_WIDTH-1:0] m);
    logic [DATA_WIDTH-1:0] r;
    r = DATA_ZERO;
    for (int i = 0; i < WMASK_WIDTH; i++) begin
      r[i*LANE_W +: LANE_W] = {LANE_W{m[i]}};
    end
    return r;
  endfunction

  state_e                  state_q;
  logic [IDX_W-1:0]        clr_cnt_q;
  logic                    init_done_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    clearing_s;
  logic                    rd0_acc_s;
  logic                    wr0_acc_s;
  logic                    rd1_acc_s;
  logic                    inr0_s;
  logic                    inr1_s;
  logic [IDX_W-1:0]        idx0_s;
  logic [IDX_W-1:0]        idx1_s;
  logic [DATA_WIDTH-1:0]   bitmask_s;
  logic [DATA_WIDTH-1:0]   old0_s;
  logic [DATA_WIDTH-1:0]   old1_s;
  logic [DATA_WIDTH-1:0]   wr_merge_s;
  logic [DATA_WIDTH-1:0]   rd0_d;
  logic [DATA_WIDTH-1:0]   rd1_d;

  logic                    p0_v1_q;
  logic                    p1_v1_q;
  logic [DATA_WIDTH-1:0]   p0_d1_q;
  logic [DATA_WIDTH-1:0]   p1_d1_q;

  // Control FSM: clear sweep over every word, then run until the next reset.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      clr_cnt_q   <= IDX_ZERO;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (clr_cnt_q == LAST_IDX) begin
            state_q     <= ST_RUN;
            clr_cnt_q   <= IDX_ZERO;
            init_done_q <= 1'b1;
          end else begin
            clr_cnt_q   <= clr_cnt_q + IDX_ONE;
            init_done_q <= 1'b0;
          end
        end
        ST_RUN: begin
          init_done_q <= 1'b1;
        end
        default: begin
          state_q     <= RESET_STATE;
          clr_cnt_q   <= IDX_ZERO;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign init_done  = init_done_q;
  assign req0_ready = init_done_q;
  assign req1_ready = init_done_q;

  assign clearing_s = (state_q == ST_CLEAR);
  assign rd0_acc_s  = req0_valid & init_done_q & ~req0_we;
  assign wr0_acc_s  = req0_valid & init_done_q & req0_we;
  assign rd1_acc_s  = req1_valid & init_done_q;
  assign inr0_s     = ({1'b0, req0_addr} < DEPTH_EXT);
  assign inr1_s     = ({1'b0, req1_addr} < DEPTH_EXT);
  assign idx0_s     = req0_addr[IDX_W-1:0];
  assign idx1_s     = req1_addr[IDX_W-1:0];

  // Array lookups (pre-edge contents), masked write merge and port-1 forwarding.
  always_comb begin
    bitmask_s = expand_mask(req0_wmask);
    if (inr0_s) begin
      old0_s = mem_q[idx0_s];
    end else begin
      old0_s = DATA_ZERO;
    end
    if (inr1_s) begin
      old1_s = mem_q[idx1_s];
    end else begin
      old1_s = DATA_ZERO;
    end
    wr_merge_s = (old0_s & ~bitmask_s) | (req0_wdata & bitmask_s);
    rd0_d      = old0_s;
    if ((FORWARD != 0) && wr0_acc_s && inr0_s && (req1_addr == req0_addr)) begin
      rd1_d = wr_merge_s;
    end else begin
      rd1_d = old1_s;
    end
  end

  // Storage array: clear sweep has priority, then in-range masked writes; never reset.
  always_ff @(posedge clk0) begin
    if (clearing_s) begin
      mem_q[clr_cnt_q] <= DATA_ZERO;
    end else if (wr0_acc_s && inr0_s) begin
      mem_q[idx0_s] <= wr_merge_s;
    end
  end

  // First read stage: capture looked-up data only on accepted reads so it holds otherwise.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      p0_v1_q <= 1'b0;
      p1_v1_q <= 1'b0;
      p0_d1_q <= DATA_ZERO;
      p1_d1_q <= DATA_ZERO;
    end else begin
      p0_v1_q <= rd0_acc_s;
      p1_v1_q <= rd1_acc_s;
      if (rd0_acc_s) begin
        p0_d1_q <= rd0_d;
      end
      if (rd1_acc_s) begin
        p1_d1_q <= rd1_d;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  p0_v2_q;
      logic                  p1_v2_q;
      logic [DATA_WIDTH-1:0] p0_d2_q;
      logic [DATA_WIDTH-1:0] p1_d2_q;

      // Second read stage: extra output register, data again held between responses.
      always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
          p0_v2_q <= 1'b0;
          p1_v2_q <= 1'b0;
          p0_d2_q <= DATA_ZERO;
          p1_d2_q <= DATA_ZERO;
        end else begin
          p0_v2_q <= p0_v1_q;
          p1_v2_q <= p1_v1_q;
          if (p0_v1_q) begin
            p0_d2_q <= p0_d1_q;
          end
          if (p1_v1_q) begin
            p1_d2_q <= p1_d1_q;
          end
        end
      end

      assign rsp0_valid = p0_v2_q;
      assign rsp0_rdata = p0_d2_q;
      assign rsp1_valid = p1_v2_q;
      assign rsp1_rdata = p1_d2_q;
    end else begin : g_lat1
      assign rsp0_valid = p0_v1_q;
      assign rsp0_rdata = p0_d1_q;
      assign rsp1_valid = p1_v1_q;
      assign rsp1_rdata = p1_d1_q;
    end
  endgenerate

endmodule
